// File: rtl/rc4_decrypt.sv
// rc4_decrypt: RC4 receive engine (S-box fill, key schedule, keystream XOR) with valid/ready on both sides.
// Optional macro RC4_DROP_EN discards the first DROP_N keystream bytes after the key schedule.
module rc4_decrypt #(
    parameter int KEY_LEN = 1,
    parameter int DROP_N  = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*KEY_LEN-1:0] password,
    input  logic                 key_load,
    output logic                 init_done,
    input  logic [7:0]           data_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [7:0]           data_out,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

    if (KEY_LEN < 1 || KEY_LEN > 16 || DROP_N < 1) begin : g_bad_param
        $error("rc4_decrypt: KEY_LEN must be 1..16 and DROP_N must be >= 1");
    end

`ifdef RC4_DROP_EN
    typedef enum logic [2:0] {IDLE, FILL, KSA, DROP, READY} state_t;
`else
    typedef enum logic [1:0] {IDLE, FILL, KSA, READY} state_t;
`endif

    state_t               state, state_nx;
    logic [7:0]           sbox [256];
    logic [7:0]           i, j;
    logic [KW-1:0]        kidx;
    logic [8*KEY_LEN-1:0] key_reg;
    logic [7:0]           key_byte;
    logic [7:0]           idx_a, s_a, j_sum, s_b, t_idx, ks;
    logic                 accept, step;

`ifdef RC4_DROP_EN
    localparam int DW = (DROP_N > 1) ? $clog2(DROP_N) : 1;
    logic [DW-1:0] drop_cnt;
    logic          drop_last;
    assign drop_last = (drop_cnt == DW'(DROP_N - 1));
    assign step      = (state == DROP) | ((state == READY) & accept);
`else
    assign step      = (state == READY) & accept;
`endif

    assign init_done = (state == READY);
    // key_load takes priority over an arriving byte so the old keystream is never consumed.
    assign in_ready  = init_done & (~out_valid | out_ready) & ~key_load;
    assign accept    = in_valid & in_ready;

    always_comb begin
        key_byte = 8'h00;
        for (int k = 0; k < KEY_LEN; k++) begin
            if (kidx == KW'(k)) key_byte = key_reg[8*k +: 8];
        end
    end

    // Shared swap datapath: KSA uses S[i], PRGA/DROP use S[i+1]; keystream byte reads post-swap values.
    always_comb begin
        idx_a = (state == KSA) ? i : i + 8'd1;
        s_a   = sbox[idx_a];
        j_sum = (state == KSA) ? j + s_a + key_byte : j + s_a;
        s_b   = sbox[j_sum];
        t_idx = s_a + s_b;
        if (t_idx == idx_a)      ks = s_b;
        else if (t_idx == j_sum) ks = s_a;
        else                     ks = sbox[t_idx];
    end

    always_comb begin
        state_nx = state;
        case (state)
            FILL:    if (i == 8'hff) state_nx = KSA;
`ifdef RC4_DROP_EN
            KSA:     if (i == 8'hff) state_nx = DROP;
            DROP:    if (drop_last) state_nx = READY;
`else
            KSA:     if (i == 8'hff) state_nx = READY;
`endif
            default: state_nx = state;
        endcase
        if (key_load) state_nx = FILL;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // S-box needs no reset: FILL rewrites every entry before it is read.
    always_ff @(posedge clk) begin
        if (state == FILL) begin
            sbox[i] <= i;
        end else if (state == KSA || step) begin
            sbox[idx_a] <= s_b;
            sbox[j_sum] <= s_a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            i         <= 8'h00;
            j         <= 8'h00;
            kidx      <= '0;
            key_reg   <= '0;
            out_valid <= 1'b0;
            data_out  <= 8'h00;
`ifdef RC4_DROP_EN
            drop_cnt  <= '0;
`endif
        end else if (key_load) begin
            key_reg   <= password;
            i         <= 8'h00;
            j         <= 8'h00;
            kidx      <= '0;
            out_valid <= 1'b0;
`ifdef RC4_DROP_EN
            drop_cnt  <= '0;
`endif
        end else begin
            case (state)
                FILL: i <= i + 8'd1;
                KSA: begin
                    i    <= i + 8'd1;
                    j    <= (i == 8'hff) ? 8'h00 : j_sum;
                    kidx <= (kidx == KW'(KEY_LEN - 1)) ? '0 : kidx + 1'b1;
                end
                default: ;
            endcase
            if (step) begin
                i <= idx_a;
                j <= j_sum;
            end
`ifdef RC4_DROP_EN
            if (state == DROP) drop_cnt <= drop_cnt + 1'b1;
`endif
            // Output stage boundary: one-entry holding register toward the sink.
            if (accept) begin
                data_out  <= data_in ^ ks;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rc4_decrypt.sv
// tb_rc4_decrypt: scoreboard bench for rc4_decrypt (KEY_LEN=3 "Key" and KEY_LEN=4 "Wiki" instances).
`timescale 1ns/1ps
module tb_rc4_decrypt;
    localparam int DROP_N_TB = 256;
`ifdef RC4_DROP_EN
    localparam int INIT_LAT = 512 + DROP_N_TB;
`else
    localparam int INIT_LAT = 512;
`endif
    localparam logic [23:0] KEY3 = 24'h79654B;
    localparam logic [31:0] KEY4 = 32'h696B6957;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] password3;
    logic [31:0] password4;
    logic        key_load3, init_done3, in_valid3, in_ready3, out_valid3, out_ready3;
    logic        key_load4, init_done4, in_valid4, in_ready4, out_valid4, out_ready4;
    logic [7:0]  data_in3, data_out3, data_in4, data_out4;

    int errors = 0;
    int checks = 0;
    int n_out3 = 0;
    int n_out4 = 0;
    logic [7:0] sb3 [$];
    logic [7:0] sb4 [$];
    logic [7:0] ct3 [9];
    logic [7:0] exp3 [9];
    logic [7:0] ct4 [5];
    logic [7:0] exp4 [5];
    logic [7:0] held3;
    bit         holding3 = 1'b0;

    always #5 clk = ~clk;

    rc4_decrypt #(.KEY_LEN(3), .DROP_N(DROP_N_TB)) dut3 (
        .clk(clk), .rst(rst), .password(password3), .key_load(key_load3), .init_done(init_done3),
        .data_in(data_in3), .in_valid(in_valid3), .in_ready(in_ready3),
        .data_out(data_out3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    rc4_decrypt #(.KEY_LEN(4), .DROP_N(DROP_N_TB)) dut4 (
        .clk(clk), .rst(rst), .password(password4), .key_load(key_load4), .init_done(init_done4),
        .data_in(data_in4), .in_valid(in_valid4), .in_ready(in_ready4),
        .data_out(data_out4), .out_valid(out_valid4), .out_ready(out_ready4)
    );

`ifdef RC4_DROP_EN
    function automatic logic [7:0] ref_ks(input logic [7:0] kb [16], input int klen, input int n);
        logic [7:0] s [256];
        logic [7:0] tmp;
        int a, b;
        for (int x = 0; x < 256; x++) s[x] = 8'(x);
        b = 0;
        for (int x = 0; x < 256; x++) begin
            b = (b + int'(s[x]) + int'(kb[x % klen])) % 256;
            tmp = s[x]; s[x] = s[b]; s[b] = tmp;
        end
        a = 0; b = 0; tmp = 8'h00;
        for (int x = 0; x <= n; x++) begin
            a = (a + 1) % 256;
            b = (b + int'(s[a])) % 256;
            tmp = s[a]; s[a] = s[b]; s[b] = tmp;
            tmp = s[(int'(s[a]) + int'(s[b])) % 256];
        end
        return tmp;
    endfunction
`endif

    // Output side: pop expected bytes on each transfer, and watch stall behaviour.
    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (holding3) begin
                    checks++;
                    if (out_valid3 !== 1'b1 || data_out3 !== held3) begin
                        errors++;
                        $display("FAIL stall_hold: out_valid=%0b data_out=%02h required out_valid=1 data_out=%02h",
                                 out_valid3, data_out3, held3);
                    end
                end
                if (out_valid3 === 1'b1 && out_ready3 === 1'b0) begin
                    checks++;
                    if (in_ready3 !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_in_ready: in_ready=%0b required 0", in_ready3);
                    end
                end
                if (out_valid3 === 1'b1 && out_ready3 === 1'b1) begin
                    n_out3++;
                    checks++;
                    if (sb3.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out3: data_out=%02h with no byte outstanding", data_out3);
                    end else begin
                        e = sb3.pop_front();
                        if (data_out3 !== e) begin
                            errors++;
                            $display("FAIL data3: data_out=%02h required %02h", data_out3, e);
                        end
                    end
                end
                holding3 = (out_valid3 === 1'b1) && (out_ready3 === 1'b0) && (key_load3 === 1'b0);
                held3    = data_out3;
                if (out_valid4 === 1'b1 && out_ready4 === 1'b1) begin
                    n_out4++;
                    checks++;
                    if (sb4.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out4: data_out=%02h with no byte outstanding", data_out4);
                    end else begin
                        e = sb4.pop_front();
                        if (data_out4 !== e) begin
                            errors++;
                            $display("FAIL data4: data_out=%02h required %02h", data_out4, e);
                        end
                    end
                end
            end else begin
                holding3 = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: time limit reached with errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // Drives ct3[first..last]; pushes the expected plaintext when a byte is accepted.
    task automatic drive3(input int first, input int last, input bit rnd, output int cycles);
        int k;
        k = first;
        cycles = 0;
        while (k <= last && cycles < 2000) begin
            if (rnd) begin
                in_valid3  = ($urandom_range(0, 1) == 1);
                out_ready3 = ~out_ready3;
            end else begin
                in_valid3 = 1'b1;
            end
            data_in3 = ct3[k];
            @(negedge clk);
            if (in_valid3 && in_ready3 === 1'b1) begin
                sb3.push_back(exp3[k]);
                k++;
            end
            @(posedge clk); #1;
            cycles++;
        end
        in_valid3 = 1'b0;
        checks++;
        if (k <= last) begin
            errors++;
            $display("FAIL drive3_timeout: accepted up to index %0d required %0d", k - 1, last);
        end
    endtask

    task automatic wait_drain3(input bit toggle);
        int g;
        g = 0;
        while ((sb3.size() != 0 || out_valid3 !== 1'b0) && g < 200) begin
            @(posedge clk); #1;
            if (toggle) out_ready3 = ~out_ready3;
            g++;
        end
        out_ready3 = 1'b1;
        checks++;
        if (sb3.size() != 0 || out_valid3 !== 1'b0) begin
            errors++;
            $display("FAIL drain3: outstanding=%0d out_valid=%0b required 0 and 0", sb3.size(), out_valid3);
        end
    endtask

    task automatic load_key3(input logic [23:0] key);
        password3 = key;
        key_load3 = 1'b1;
        @(posedge clk); #1;
        key_load3 = 1'b0;
        checks++;
        if (init_done3 !== 1'b0 || out_valid3 !== 1'b0) begin
            errors++;
            $display("FAIL keyload_clear: init_done=%0b out_valid=%0b required 0 0", init_done3, out_valid3);
        end
        repeat (INIT_LAT - 1) @(posedge clk);
        #1;
        checks++;
        if (init_done3 !== 1'b0) begin
            errors++;
            $display("FAIL init_early3: init_done=%0b required 0 one cycle before done", init_done3);
        end
        @(posedge clk); #1;
        checks++;
        if (init_done3 !== 1'b1) begin
            errors++;
            $display("FAIL init_time3: init_done=%0b required 1 at T0+%0d", init_done3, INIT_LAT + 1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        in_valid3 = 1'b1;
        in_valid4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (init_done3 !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %0b required 0", init_done3); end
        checks++;
        if (out_valid3 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid3); end
        checks++;
        if (data_out3 !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %02h required 00", data_out3); end
        checks++;
        if (in_ready3 !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b required 0", in_ready3); end
        checks++;
        if ({init_done4, out_valid4, in_ready4, data_out4} !== 11'h000) begin
            errors++;
            $display("FAIL reset_dut4: got %03h required 000", {init_done4, out_valid4, in_ready4, data_out4});
        end
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (init_done3 !== 1'b0 || in_ready3 !== 1'b0 || out_valid3 !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores_input: init_done=%0b in_ready=%0b out_valid=%0b required 0 0 0",
                     init_done3, in_ready3, out_valid3);
        end
        in_valid3 = 1'b0;
        in_valid4 = 1'b0;
    endtask

    task automatic test_key_vector;
        int cyc, n0;
        out_ready3 = 1'b1;
        load_key3(KEY3);
        n0 = n_out3;
        drive3(0, 8, 1'b0, cyc);
        checks++;
        if (cyc != 9) begin errors++; $display("FAIL throughput: %0d cycles for 9 bytes required 9", cyc); end
        checks++;
        if (out_valid3 !== 1'b1 || data_out3 !== exp3[8]) begin
            errors++;
            $display("FAIL latency: out_valid=%0b data_out=%02h required 1 %02h", out_valid3, data_out3, exp3[8]);
        end
        wait_drain3(1'b0);
        checks++;
        if (n_out3 - n0 != 9) begin errors++; $display("FAIL count_key: got %0d bytes required 9", n_out3 - n0); end
    endtask

    task automatic test_wiki;
        password4 = KEY4;
        key_load4 = 1'b1;
        @(posedge clk); #1;
        key_load4 = 1'b0;
        repeat (INIT_LAT - 1) @(posedge clk);
        #1;
        checks++;
        if (init_done4 !== 1'b0) begin errors++; $display("FAIL init_early4: got %0b required 0", init_done4); end
        @(posedge clk); #1;
        checks++;
        if (init_done4 !== 1'b1) begin errors++; $display("FAIL init_time4: got %0b required 1", init_done4); end
        out_ready4 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid4 = 1'b1;
            data_in4  = ct4[k];
            @(negedge clk);
            checks++;
            if (in_ready4 !== 1'b1) begin
                errors++;
                $display("FAIL wiki_in_ready: byte %0d in_ready=%0b required 1", k, in_ready4);
            end else begin
                sb4.push_back(exp4[k]);
            end
            @(posedge clk); #1;
        end
        in_valid4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb4.size() != 0 || n_out4 != 5) begin
            errors++;
            $display("FAIL count_wiki: outstanding=%0d outputs=%0d required 0 5", sb4.size(), n_out4);
        end
    endtask

    task automatic test_backpressure;
        int cyc, n0;
        out_ready3 = 1'b1;
        load_key3(KEY3);
        n0 = n_out3;
        drive3(0, 8, 1'b1, cyc);
        wait_drain3(1'b1);
        checks++;
        if (n_out3 - n0 != 9) begin errors++; $display("FAIL count_bp: got %0d bytes required 9", n_out3 - n0); end
    endtask

    task automatic test_rekey;
        int cyc, n0;
        out_ready3 = 1'b1;
        load_key3(KEY3);
        drive3(0, 3, 1'b0, cyc);
        wait_drain3(1'b0);
        out_ready3 = 1'b0;
        drive3(4, 4, 1'b0, cyc);
        @(posedge clk); #1;
        checks++;
        if (out_valid3 !== 1'b1 || data_out3 !== exp3[4]) begin
            errors++;
            $display("FAIL rekey_pending: out_valid=%0b data_out=%02h required 1 %02h", out_valid3, data_out3, exp3[4]);
        end
        sb3.delete();
        load_key3(KEY3);
        out_ready3 = 1'b1;
        n0 = n_out3;
        drive3(0, 8, 1'b0, cyc);
        wait_drain3(1'b0);
        checks++;
        if (n_out3 - n0 != 9) begin errors++; $display("FAIL count_rekey: got %0d bytes required 9", n_out3 - n0); end
    endtask

    task automatic test_reset_mid_ksa;
        out_ready3 = 1'b1;
        in_valid3  = 1'b1;
        data_in3   = 8'h55;
        password3  = KEY3;
        key_load3  = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready3 !== 1'b0) begin errors++; $display("FAIL keyload_wins: in_ready=%0b required 0", in_ready3); end
        @(posedge clk); #1;
        key_load3 = 1'b0;
        checks++;
        if (out_valid3 !== 1'b0) begin errors++; $display("FAIL keyload_no_consume: out_valid=%0b required 0", out_valid3); end
        repeat (299) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (init_done3 !== 1'b0) begin errors++; $display("FAIL midksa_init_done: got %0b required 0", init_done3); end
        checks++;
        if (out_valid3 !== 1'b0) begin errors++; $display("FAIL midksa_out_valid: got %0b required 0", out_valid3); end
        checks++;
        if (data_out3 !== 8'h00) begin errors++; $display("FAIL midksa_data_out: got %02h required 00", data_out3); end
        checks++;
        if (in_ready3 !== 1'b0) begin errors++; $display("FAIL midksa_in_ready: got %0b required 0", in_ready3); end
        rst = 1'b1;
        repeat (600) @(posedge clk);
        #1;
        checks++;
        if (init_done3 !== 1'b0 || in_ready3 !== 1'b0) begin
            errors++;
            $display("FAIL midksa_stays_idle: init_done=%0b in_ready=%0b required 0 0", init_done3, in_ready3);
        end
        in_valid3 = 1'b0;
    endtask

    initial begin : main
        logic [7:0] kb3 [16];
        logic [7:0] kb4 [16];
        rst = 1'b0;
        password3 = '0; key_load3 = 1'b0; in_valid3 = 1'b0; data_in3 = 8'h00; out_ready3 = 1'b1;
        password4 = '0; key_load4 = 1'b0; in_valid4 = 1'b0; data_in4 = 8'h00; out_ready4 = 1'b1;
        ct3 = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        ct4 = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
        for (int k = 0; k < 16; k++) begin
            kb3[k] = 8'h00;
            kb4[k] = 8'h00;
        end
        kb3[0] = 8'h4B; kb3[1] = 8'h65; kb3[2] = 8'h79;
        kb4[0] = 8'h57; kb4[1] = 8'h69; kb4[2] = 8'h6B; kb4[3] = 8'h69;
`ifdef RC4_DROP_EN
        for (int k = 0; k < 9; k++) exp3[k] = ct3[k] ^ ref_ks(kb3, 3, DROP_N_TB + k);
        for (int k = 0; k < 5; k++) exp4[k] = ct4[k] ^ ref_ks(kb4, 4, DROP_N_TB + k);
`else
        exp3 = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        exp4 = '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
        kb3[0] = kb3[0];
        kb4[0] = kb4[0];
`endif
        test_reset();
        test_key_vector();
        test_wiki();
        test_backpressure();
        test_rekey();
        test_reset_mid_ksa();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
